sram_block_responder: RTL and testbench

- Memory-side responder for the data-cache miss/write-through interface.
- Accepts single-word write requests and two-word (64-bit block) read requests from the cache.
- Sequences them onto an asynchronous 32-bit external SRAM with a fixed wait-state count.
- Holds ready low while busy, which freezes the pipeline through the existing ~ready freeze path.

---
 rtl/sram_resp_pkg.sv | 17 +
 rtl/sram_wait_counter.sv | 36 +++
 rtl/sram_block_responder.sv | 119 +++++++++++
 tb/tb_sram_block_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and helpers for the SRAM block responder: FSM state encoding,
// default data-region base and the byte-to-word address mapping.
package sram_resp_pkg;

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR, DONE} state_t;

   localparam int unsigned DATA_BASE_DEFAULT = 32'd1024;

   // Offset wraps modulo 2^32; callers truncate to their SRAM word width.
   function automatic logic [31:0] word_index(input logic [31:0] address,
                                              input logic [31:0] base);
      logic [31:0] offset;
      offset = address - base;
      return offset >> 2;
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: counts enabled clocks and flags the last one of each
// WAIT_CYCLES-long access window, then rearms itself.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int unsigned CntW = 4;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc = en && (cnt_q == CntW'(WAIT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load || tc) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_block_responder.sv
// Cache-side responder sequencing word writes and 64-bit block reads onto an
// async 32-bit SRAM. Define SRAM_POSTED_WRITE_EN to accept writes without stalling.
module sram_block_responder
   import sram_resp_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DATA_BASE   = DATA_BASE_DEFAULT,
   parameter int unsigned ADDR_W      = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_en,
   input  logic              read_en,
   input  logic [31:0]       address,
   input  logic [31:0]       writeData,
   output logic [63:0]       readData,
   output logic              ready,
   inout  wire  [31:0]       SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_WE_N
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] word_q;
   logic [31:0]       wdata_q;
   logic              access;
   logic              tc;
   logic              dq_drive;

   assign access = (state_q == RD0) || (state_q == RD1) || (state_q == WR);

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk (clk),
      .rst (rst),
      .load(~access),
      .en  (access),
      .tc  (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (write_en) begin
               state_d = WR;
            end else if (read_en) begin
               state_d = RD0;
            end
         end
         RD0:  if (tc) state_d = RD1;
         RD1:  if (tc) state_d = DONE;
`ifdef SRAM_POSTED_WRITE_EN
         WR:   if (tc) state_d = IDLE;
`else
         WR:   if (tc) state_d = DONE;
`endif
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      dq_drive  = 1'b0;
      unique case (state_q)
`ifdef SRAM_POSTED_WRITE_EN
         // Writes are absorbed immediately; only a lone read stalls.
         IDLE: ready = write_en | ~read_en;
`else
         IDLE: ready = ~(read_en | write_en);
`endif
         RD0:  SRAM_ADDR = {word_q[ADDR_W-1:1], 1'b0};
         RD1:  SRAM_ADDR = {word_q[ADDR_W-1:1], 1'b1};
         WR: begin
            SRAM_ADDR = word_q;
            SRAM_WE_N = 1'b0;
            dq_drive  = 1'b1;
         end
         DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign SRAM_DQ = dq_drive ? wdata_q : 'z;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q   <= '0;
         wdata_q  <= '0;
         readData <= '0;
      end else begin
         if (state_q == IDLE && (write_en || read_en)) begin
            word_q <= ADDR_W'(word_index(address, DATA_BASE));
         end
         if (state_q == IDLE && write_en) begin
            wdata_q <= writeData;
         end
         if (tc && state_q == RD0) begin
            readData[31:0] <= SRAM_DQ;
         end
         if (tc && state_q == RD1) begin
            readData[63:32] <= SRAM_DQ;
         end
      end
   end

endmodule

// File: tb/tb_sram_block_responder.sv
// Directed self-checking bench for sram_block_responder with a behavioural
// async SRAM on the shared data bus.
module tb_sram_block_responder;

   localparam int unsigned WAIT_CYCLES = 2;
   localparam int unsigned ADDR_W      = 17;
   localparam logic [31:0] IdlePat     = 32'hA5A5_5A5A;

   logic              clk = 1'b0;
   logic              rst;
   logic              write_en;
   logic              read_en;
   logic [31:0]       address;
   logic [31:0]       writeData;
   logic [63:0]       readData;
   logic              ready;
   wire  [31:0]       SRAM_DQ;
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_WE_N;

   logic              tb_idle;
   logic [31:0]       mem [0:(1<<ADDR_W)-1];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // SRAM drives the bus whenever it is not being written; tb_idle swaps in a
   // fixed pattern so an unwanted DUT driver shows up as a corrupted value.
   assign SRAM_DQ = SRAM_WE_N ? (tb_idle ? IdlePat : mem[SRAM_ADDR]) : 'z;

   always @(posedge clk) begin
      if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
   end

   sram_block_responder #(
      .WAIT_CYCLES(WAIT_CYCLES),
      .DATA_BASE  (1024),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .write_en (write_en),
      .read_en  (read_en),
      .address  (address),
      .writeData(writeData),
      .readData (readData),
      .ready    (ready),
      .SRAM_DQ  (SRAM_DQ),
      .SRAM_ADDR(SRAM_ADDR),
      .SRAM_WE_N(SRAM_WE_N)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request, counts cycles until ready (bounded), then retires it.
   task automatic request(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input int exp_cyc, input string tag);
      int cyc = 0;
      write_en  = we;
      read_en   = re;
      address   = a;
      writeData = d;
      #1;
      while (!ready && cyc < 40) begin
         step();
         cyc++;
      end
      chk(tag, 64'(cyc), 64'(exp_cyc));
      step();
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      write_en  = 1'b0;
      read_en   = 1'b0;
      address   = '0;
      writeData = '0;
      tb_idle   = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("rst_readdata", readData, 64'd0);
      chk("rst_addr", 64'(SRAM_ADDR), 64'd0);
      chk("rst_dq", 64'(SRAM_DQ), 64'(IdlePat));
      tb_idle = 1'b0;
   endtask

   initial begin
      do_reset();
`ifdef SRAM_POSTED_WRITE_EN
      request(1'b1, 1'b0, 32'd1036, 32'h2222_2222, 0, "pw_first_lat");
      step();
      step();
      step();
      chk("pw_mem3", 64'(mem[3]), 64'h2222_2222);

      write_en  = 1'b1;
      address   = 32'd1032;
      writeData = 32'hDEAD_BEEF;
      #1;
      chk("pw_c0_ready", 64'(ready), 64'd1);
      step();
      write_en = 1'b0;
      read_en  = 1'b1;
      #1;
      chk("pw_c1_ready", 64'(ready), 64'd0);
      chk("pw_c1_we_n", 64'(SRAM_WE_N), 64'd0);
      // Write drains (1 more clock), then IDLE, then a full 5-cycle read.
      request(1'b0, 1'b1, 32'd1032, 32'h0, 7, "pw_read_lat");
      chk("pw_read_data", readData, 64'h2222_2222_DEAD_BEEF);
`else
      // Single write to word 2 with per-cycle bus checks.
      write_en  = 1'b1;
      address   = 32'd1032;
      writeData = 32'hDEAD_BEEF;
      #1;
      chk("wr_c0_ready", 64'(ready), 64'd0);
      step();
      chk("wr_c1_addr", 64'(SRAM_ADDR), 64'd2);
      chk("wr_c1_we_n", 64'(SRAM_WE_N), 64'd0);
      chk("wr_c1_dq", 64'(SRAM_DQ), 64'hDEAD_BEEF);
      chk("wr_c1_ready", 64'(ready), 64'd0);
      step();
      chk("wr_c2_we_n", 64'(SRAM_WE_N), 64'd0);
      chk("wr_c2_ready", 64'(ready), 64'd0);
      step();
      chk("wr_c3_ready", 64'(ready), 64'd1);
      chk("wr_c3_we_n", 64'(SRAM_WE_N), 64'd1);
      write_en = 1'b0;
      step();
      chk("wr_c4_ready", 64'(ready), 64'd1);
      chk("wr_mem2", 64'(mem[2]), 64'hDEAD_BEEF);
      chk("wr_readdata", readData, 64'd0);

      request(1'b1, 1'b0, 32'd1032, 32'h1111_1111, 3, "wr_w2_lat");
      request(1'b1, 1'b0, 32'd1036, 32'h2222_2222, 3, "wr_w3_lat");
      request(1'b1, 1'b0, 32'd1028, 32'h1234_5678, 3, "wr_w1_lat");

      // Block read of words 2/3 via the odd word's byte address.
      read_en = 1'b1;
      address = 32'd1036;
      #1;
      chk("rd_c0_ready", 64'(ready), 64'd0);
      step();
      chk("rd_c1_addr", 64'(SRAM_ADDR), 64'd2);
      chk("rd_c1_we_n", 64'(SRAM_WE_N), 64'd1);
      step();
      step();
      chk("rd_c3_addr", 64'(SRAM_ADDR), 64'd3);
      chk("rd_c3_lo", 64'(readData[31:0]), 64'h1111_1111);
      step();
      step();
      chk("rd_c5_ready", 64'(ready), 64'd1);
      chk("rd_data", readData, 64'h2222_2222_1111_1111);
      read_en = 1'b0;
      step();
      chk("rd_hold", readData, 64'h2222_2222_1111_1111);

      request(1'b1, 1'b1, 32'd1024, 32'h0000_CAFE, 3, "both_lat");
      chk("both_mem0", 64'(mem[0]), 64'h0000_CAFE);
      chk("both_readdata", readData, 64'h2222_2222_1111_1111);

      // 1020 - 1024 wraps to 0xFFFFFFFC, i.e. the top SRAM word.
      request(1'b1, 1'b0, 32'd1020, 32'h7777_7777, 3, "alias_lat");
      chk("alias_mem", 64'(mem[17'h1FFFF]), 64'h7777_7777);

      // Reset while in RD1, then a clean read of words 0/1.
      read_en = 1'b1;
      address = 32'd1032;
      #1;
      step();
      step();
      step();
      chk("mr_c3_addr", 64'(SRAM_ADDR), 64'd3);
      rst     = 1'b1;
      read_en = 1'b0;
      tb_idle = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mr_ready", 64'(ready), 64'd1);
      chk("mr_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("mr_dq", 64'(SRAM_DQ), 64'(IdlePat));
      chk("mr_addr", 64'(SRAM_ADDR), 64'd0);
      tb_idle = 1'b0;
      request(1'b0, 1'b1, 32'd1028, 32'h0, 5, "mr_read_lat");
      chk("mr_read_data", readData, 64'h1234_5678_0000_CAFE);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
